// File: rtl/crypto_pkg.sv
// crypto_pkg: shared types, mode constants and width-generic rotate helpers
// for the iterative cipher engine.
//   state_e          : engine FSM states (ST_IDLE, ST_RUN, ST_DONE)
//   MODE_ENC/DEC     : value of the registered decrypt flag
//   rotl/rotr        : rotate the low w bits of a MAX_W-wide word by n
package crypto_pkg;

  localparam int unsigned MAX_W = 64;
  localparam int unsigned IDX_W = $clog2(MAX_W);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_DEC = 1'b1;

  // Rotate left within the low w bits; bits at or above w come back as zero.
  function automatic logic [MAX_W-1:0] rotl(input logic [MAX_W-1:0] x,
                                            input int unsigned w,
                                            input int unsigned n);
    logic [MAX_W-1:0] y;
    y = '0;
    for (int unsigned i = 0; i < MAX_W; i++) begin
      if (i < w) y[IDX_W'((i + n) % w)] = x[IDX_W'(i)];
    end
    return y;
  endfunction

  // Rotate right expressed as the complementary left rotate.
  function automatic logic [MAX_W-1:0] rotr(input logic [MAX_W-1:0] x,
                                            input int unsigned w,
                                            input int unsigned n);
    return rotl(x, w, (w - (n % w)) % w);
  endfunction

endpackage

// File: rtl/crypto_if.sv
// crypto_if: request/response handshake bundle of the cipher engine.
//   request : in_valid/in_ready, in_data, in_key, in_decrypt, abort
//   response: out_valid/out_ready, out_data
//   master  : requester side (CPU control unit or testbench)
//   slave   : engine side
interface crypto_if #(
  parameter int unsigned DATA_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [DATA_W-1:0] in_key;
  logic              in_decrypt;
  logic              abort;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;

  modport master (
    output in_valid, in_data, in_key, in_decrypt, abort, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_key, in_decrypt, abort, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/crypto_round.sv
// crypto_round: one combinational cipher round.
//   s, k    : current state word and base key
//   r       : round index; key is rotated by r mod DATA_W, r is added/subtracted
//   mode    : MODE_ENC or MODE_DEC
//   s_nxt_c : state after this round
module crypto_round
  import crypto_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ROUNDS = 4,
  parameter int unsigned ROT    = 1
) (
  input  logic [DATA_W-1:0]        s,
  input  logic [DATA_W-1:0]        k,
  input  logic [$clog2(ROUNDS):0]  r,
  input  logic                     mode,
  output logic [DATA_W-1:0]        s_nxt_c
);

  logic [DATA_W-1:0] kr;
  logic [DATA_W-1:0] rv;
  logic [DATA_W-1:0] t;

  // Decrypt undoes the encrypt steps in reverse order: subtract, rotate back, unmask.
  always_comb begin
    kr      = DATA_W'(rotl(MAX_W'(k), DATA_W, 32'(r) % DATA_W));
    rv      = DATA_W'(r);
    t       = '0;
    s_nxt_c = '0;
    if (mode == MODE_DEC) begin
      t       = s - rv;
      s_nxt_c = DATA_W'(rotr(MAX_W'(t), DATA_W, ROT)) ^ kr;
    end else begin
      t       = s ^ kr;
      s_nxt_c = DATA_W'(rotl(MAX_W'(t), DATA_W, ROT)) + rv;
    end
  end

endmodule

// File: rtl/crypto_engine.sv
// crypto_engine: iterative multi-round cipher coprocessor, one round per clock.
//   clk, reset_n : clock and asynchronous active-low reset
//   bus          : crypto_if slave (request and response handshakes, abort)
//   busy         : high while a block is running or waiting to be taken
//   round_idx    : round about to be applied (debug)
//   blk_count    : completed (handed-off) blocks, wrapping
module crypto_engine
  import crypto_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ROUNDS = 4,
  parameter int unsigned ROT    = 1,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  crypto_if.slave                  bus,
  output logic                     busy,
  output logic [$clog2(ROUNDS):0]  round_idx,
  output logic [CNT_W-1:0]         blk_count
);

  localparam int unsigned   RW     = $clog2(ROUNDS) + 1;
  localparam logic [RW-1:0] R_LAST = RW'(ROUNDS - 1);

  state_e            state;
  logic [DATA_W-1:0] s;
  logic [DATA_W-1:0] k;
  logic              mode;
  logic [DATA_W-1:0] s_nxt_c;
  logic              last_c;

  crypto_round #(
    .DATA_W (DATA_W),
    .ROUNDS (ROUNDS),
    .ROT    (ROT)
  ) u_round (
    .s       (s),
    .k       (k),
    .r       (round_idx),
    .mode    (mode),
    .s_nxt_c (s_nxt_c)
  );

  // Encrypt counts up to ROUNDS-1, decrypt counts down to 0.
  assign last_c = (mode == MODE_DEC) ? (round_idx == '0) : (round_idx == R_LAST);

  // Control FSM with registered handshake outputs; abort beats out_ready.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      busy          <= 1'b0;
      round_idx     <= '0;
      blk_count     <= '0;
      s             <= '0;
      k             <= '0;
      mode          <= MODE_ENC;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.in_valid && !bus.abort) begin
            s            <= bus.in_data;
            k            <= bus.in_key;
            mode         <= bus.in_decrypt;
            round_idx    <= (bus.in_decrypt == MODE_DEC) ? R_LAST : '0;
            state        <= ST_RUN;
            bus.in_ready <= 1'b0;
            busy         <= 1'b1;
          end
        end
        ST_RUN: begin
          if (bus.abort) begin
            state         <= ST_IDLE;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            busy          <= 1'b0;
          end else begin
            s <= s_nxt_c;
            if (last_c) begin
              bus.out_data  <= s_nxt_c;
              bus.out_valid <= 1'b1;
              state         <= ST_DONE;
            end else if (mode == MODE_DEC) begin
              round_idx <= round_idx - RW'(1);
            end else begin
              round_idx <= round_idx + RW'(1);
            end
          end
        end
        ST_DONE: begin
          if (bus.abort || bus.out_ready) begin
            state         <= ST_IDLE;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            busy          <= 1'b0;
            if (!bus.abort) blk_count <= blk_count + CNT_W'(1);
          end
        end
        default: begin
          state         <= ST_IDLE;
          bus.in_ready  <= 1'b1;
          bus.out_valid <= 1'b0;
          busy          <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_crypto_engine.sv
// tb_crypto_engine: self-checking bench for crypto_engine.
// Three instances: ROUNDS=1 and ROUNDS=2 for the known-answer vectors, and a
// ROUNDS=4 / CNT_W=4 instance for handshake, abort, reset, wrap and random sweeps.
module tb_crypto_engine;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  crypto_if #(.DATA_W(8)) bus  ();
  crypto_if #(.DATA_W(8)) bus1 ();
  crypto_if #(.DATA_W(8)) bus2 ();

  logic        busy, busy1, busy2;
  logic [2:0]  ridx;
  logic [0:0]  ridx1;
  logic [1:0]  ridx2;
  logic [3:0]  cnt;
  logic [15:0] cnt1, cnt2;

  crypto_engine #(.DATA_W(8), .ROUNDS(4), .ROT(1), .CNT_W(4)) u_dut (
    .clk(clk), .reset_n(rst_n), .bus(bus), .busy(busy), .round_idx(ridx), .blk_count(cnt)
  );
  crypto_engine #(.DATA_W(8), .ROUNDS(1), .ROT(1), .CNT_W(16)) u_r1 (
    .clk(clk), .reset_n(rst_n), .bus(bus1), .busy(busy1), .round_idx(ridx1), .blk_count(cnt1)
  );
  crypto_engine #(.DATA_W(8), .ROUNDS(2), .ROT(1), .CNT_W(16)) u_r2 (
    .clk(clk), .reset_n(rst_n), .bus(bus2), .busy(busy2), .round_idx(ridx2), .blk_count(cnt2)
  );

  int n_cmp = 0;
  int n_err = 0;
  int exp_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: plain integer arithmetic on 8-bit words.
  function automatic int rl(input int v, input int n);
    int m;
    m = n % 8;
    return ((v << m) | (v >> (8 - m))) & 255;
  endfunction

  function automatic int rr(input int v, input int n);
    return rl(v, (8 - (n % 8)) % 8);
  endfunction

  function automatic int ref_enc(input int x, input int k, input int nr);
    int v;
    v = x;
    for (int r = 0; r < nr; r++) v = (rl(v ^ rl(k, r), 1) + r) & 255;
    return v;
  endfunction

  function automatic int ref_dec(input int x, input int k, input int nr);
    int v;
    v = x;
    for (int r = nr - 1; r >= 0; r--) v = rr((v - r) & 255, 1) ^ rl(k, r);
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rst_pulse();
    #2 rst_n = 1'b0;
    #3 rst_n = 1'b1;
    exp_cnt = 0;
    tick();
  endtask

  // One full block on the ROUNDS=4 instance; hold = cycles of backpressure in DONE.
  task automatic run_blk(input int d, input int k, input bit dec, input int hold, output int res);
    int lat;
    int exp;
    bus.in_valid   = 1'b1;
    bus.in_data    = 8'(d);
    bus.in_key     = 8'(k);
    bus.in_decrypt = dec;
    chk("acc_ready", bus.in_ready, 1);
    tick();
    bus.in_valid   = 1'b0;
    bus.in_data    = 8'($urandom);
    bus.in_key     = 8'($urandom);
    bus.in_decrypt = 1'($urandom);
    chk("run_busy", busy, 1);
    lat = 0;
    while (!bus.out_valid && lat < 50) begin
      tick();
      lat++;
    end
    chk("latency", lat, 4);
    exp = dec ? ref_dec(d, k, 4) : ref_enc(d, k, 4);
    chk("out_data", bus.out_data, exp);
    res = int'(bus.out_data);
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = i[0];
      tick();
      chk("hold_data", bus.out_data, exp);
      chk("hold_in_ready", bus.in_ready, 0);
      chk("hold_valid", bus.out_valid, 1);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    exp_cnt = (exp_cnt + 1) % 16;
    chk("ov_drop", bus.out_valid, 0);
    chk("blk_count", cnt, exp_cnt);
    chk("idle_ready", bus.in_ready, 1);
    chk("data_keep", bus.out_data, exp);
    if (hold > 0) begin
      tick();
      chk("no_queue", busy, 0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int res, res2, x, k, lat;
    rst_n = 1'b1;
    bus.in_valid = 0;  bus.in_data = 0;  bus.in_key = 0;  bus.in_decrypt = 0;  bus.abort = 0;  bus.out_ready = 0;
    bus1.in_valid = 0; bus1.in_data = 0; bus1.in_key = 0; bus1.in_decrypt = 0; bus1.abort = 0; bus1.out_ready = 0;
    bus2.in_valid = 0; bus2.in_data = 0; bus2.in_key = 0; bus2.in_decrypt = 0; bus2.abort = 0; bus2.out_ready = 0;
    #2 rst_n = 1'b0;
    #10;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_round_idx", ridx, 0);
    chk("rst_blk_count", cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("rel_in_ready", bus.in_ready, 1);

    // Known-answer vectors on the ROUNDS=1 and ROUNDS=2 instances.
    bus1.in_valid = 1; bus1.in_data = 8'h41; bus1.in_key = 8'h5A; bus1.in_decrypt = 0;
    bus2.in_valid = 1; bus2.in_data = 8'h41; bus2.in_key = 8'h5A; bus2.in_decrypt = 0;
    chk("r1_in_ready", bus1.in_ready, 1);
    tick();
    bus1.in_valid = 0; bus2.in_valid = 0;
    chk("r1_ov_accept", bus1.out_valid, 0);
    tick();
    chk("r1_ov", bus1.out_valid, 1);
    chk("r1_data", bus1.out_data, 8'h36);
    chk("r2_ov_early", bus2.out_valid, 0);
    tick();
    chk("r2_ov", bus2.out_valid, 1);
    chk("r2_data", bus2.out_data, 8'h06);
    bus1.out_ready = 1; bus2.out_ready = 1;
    tick();
    bus1.out_ready = 0; bus2.out_ready = 0;
    chk("r1_cnt", cnt1, 1);
    chk("r1_ov_drop", bus1.out_valid, 0);
    chk("r2_cnt", cnt2, 1);
    bus2.in_valid = 1; bus2.in_data = 8'h06; bus2.in_key = 8'h5A; bus2.in_decrypt = 1;
    tick();
    bus2.in_valid = 0;
    tick();
    chk("r2_dec_ov_early", bus2.out_valid, 0);
    tick();
    chk("r2_dec_ov", bus2.out_valid, 1);
    chk("r2_dec_data", bus2.out_data, 8'h41);
    bus2.out_ready = 1;
    tick();
    bus2.out_ready = 0;
    chk("r2_cnt2", cnt2, 2);

    // Main instance: known vector round trip and backpressure.
    run_blk(8'h41, 8'h5A, 1'b0, 0, res);
    run_blk(res, 8'h5A, 1'b1, 0, res2);
    chk("rt_known", res2, 8'h41);
    run_blk($urandom_range(0, 255), $urandom_range(0, 255), 1'b0, 10, res);

    // Abort in RUN after round 0.
    bus.in_valid = 1; bus.in_data = 8'h3C; bus.in_key = 8'hA5; bus.in_decrypt = 0;
    tick();
    bus.in_valid = 0;
    tick();
    chk("abort_ridx", ridx, 1);
    bus.abort = 1;
    tick();
    bus.abort = 0;
    chk("abort_busy", busy, 0);
    chk("abort_ov", bus.out_valid, 0);
    chk("abort_ready", bus.in_ready, 1);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("abort_ov_quiet", bus.out_valid, 0);
    end
    chk("abort_cnt", cnt, exp_cnt);
    // Abort in IDLE blocks the accept on that edge.
    bus.abort = 1; bus.in_valid = 1;
    tick();
    bus.abort = 0; bus.in_valid = 0;
    chk("abort_idle_noacc", busy, 0);
    run_blk(8'h12, 8'h34, 1'b0, 0, res);

    // Abort in DONE wins over out_ready.
    bus.in_valid = 1; bus.in_data = 8'h77; bus.in_key = 8'h01; bus.in_decrypt = 0;
    tick();
    bus.in_valid = 0;
    lat = 0;
    while (!bus.out_valid && lat < 50) begin
      tick();
      lat++;
    end
    chk("done_ov", bus.out_valid, 1);
    bus.abort = 1; bus.out_ready = 1;
    tick();
    bus.abort = 0; bus.out_ready = 0;
    chk("done_abort_ov", bus.out_valid, 0);
    chk("done_abort_cnt", cnt, exp_cnt);
    chk("done_abort_busy", busy, 0);

    // Asynchronous reset in the middle of RUN.
    bus.in_valid = 1; bus.in_data = 8'h99; bus.in_key = 8'h66; bus.in_decrypt = 0;
    tick();
    bus.in_valid = 0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ov", bus.out_valid, 0);
    chk("mid_rst_data", bus.out_data, 0);
    chk("mid_rst_ridx", ridx, 0);
    chk("mid_rst_cnt", cnt, 0);
    exp_cnt = 0;
    #3 rst_n = 1'b1;
    tick();
    run_blk(8'h41, 8'h5A, 1'b0, 0, res);

    // Counter wrap: 17 blocks from reset on a 4-bit counter.
    rst_pulse();
    for (int i = 0; i < 17; i++) run_blk($urandom_range(0, 255), $urandom_range(0, 255), 1'($urandom), 0, res);
    chk("wrap17", cnt, 1);

    // Random encrypt/decrypt round trips.
    for (int i = 0; i < 256; i++) begin
      x = $urandom_range(0, 255);
      k = $urandom_range(0, 255);
      run_blk(x, k, 1'b0, 0, res);
      run_blk(res, k, 1'b1, 0, res2);
      chk("rt_random", res2, x);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/crypto_engine.md
Name: crypto_engine

Overview:
Parametrised, multi-round, iterative cipher engine that succeeds the single-cycle XOR crypto unit in the mini crypto CPU.
- Accepts one plaintext or ciphertext word with a key over a valid/ready handshake.
- Runs ROUNDS rounds, one round per clock, using a rotating key schedule.
- Returns the result over a second valid/ready handshake.
- Supports both encrypt and decrypt modes.
- Sits beside the CPU ALU as a multi-cycle coprocessor. The control unit stalls on busy.

Parameters:
DATA_W, 8, word/key width in bits (>=4)
ROUNDS, 4, rounds per block (>=1)
ROT, 1, per-round rotate amount (1..DATA_W-1)
CNT_W, 16, width of the completed-block counter

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
in_valid  input  1  request valid
in_ready  output  1  engine can accept a request
in_data  input  DATA_W  plaintext (encrypt) or ciphertext (decrypt)
in_key  input  DATA_W  key
in_decrypt  input  1  0=encrypt, 1=decrypt
abort  input  1  synchronous cancel of the in-flight block
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_data  output  DATA_W  result word
busy  output  1  high in RUN or DONE
round_idx  output  clog2(ROUNDS)+1  current round index (debug)
blk_count  output  CNT_W  completed blocks, wraps at 2^CNT_W

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low, on port reset_n. While reset_n=0:
  - state=IDLE
  - out_valid=0, out_data=0, busy=0, round_idx=0, blk_count=0
  - in_ready=1 from the first cycle after release
- States:
  - IDLE: in_ready=1.
  - RUN: one round per cycle.
  - DONE: out_valid=1; out_data is held stable until out_ready.
- IDLE -> RUN: on an edge with in_valid&in_ready.
  - Register in_data into state s, in_key into k, and in_decrypt into mode.
  - round_idx = 0 (encrypt) or ROUNDS-1 (decrypt).
- Round key: k_r = rotl(k, r mod DATA_W).
- Encrypt round r: s <= rotl(s ^ k_r, ROT) + r, mod 2^DATA_W, with r zero-extended or truncated to DATA_W. r steps 0..ROUNDS-1.
- Decrypt round r: s <= rotr(s - r, ROT) ^ k_r. r steps ROUNDS-1 down to 0. Decrypt exactly inverts encrypt.
- RUN -> DONE: on the edge that performs the last round.
  - out_data <= final s, out_valid <= 1.
  - Latency: out_valid rises ROUNDS edges after the accept edge.
  - ROUNDS=1: exactly one RUN cycle.
- DONE -> IDLE: on an edge with out_ready=1. blk_count increments on the same edge; wrap-around is required.
  - out_valid drops on that edge.
  - out_data keeps the last value.
- in_ready is 1 only in IDLE; there is no overlap between blocks. in_valid outside IDLE is ignored and not queued. Maximum throughput is one block per ROUNDS+2 cycles.
- abort=1 in RUN or DONE: next edge goes to IDLE, out_valid=0, no blk_count increment.
  - abort has priority over out_ready.
  - abort in IDLE has no effect, and no accept happens on that edge.
- Input registering: in_key and in_data changes after accept have no effect on the in-flight block.
- reset_n asserted mid-RUN or in DONE: immediate return to IDLE with all reset values; the block is lost.
- busy = (state != IDLE).

Decomposition:
- Shared package crypto_pkg holds:
  - state encoding constants ST_IDLE, ST_RUN, ST_DONE
  - mode constants MODE_ENC, MODE_DEC
  - rotl/rotr functions parametrised by width
- Natural sub-module crypto_round: combinational single round. Inputs are s, k, r and mode; output is next s. Instantiated once and reused iteratively.

Test Plan:
1. DATA_W=8, ROUNDS=1, ROT=1; encrypt 0x41 with key 0x5A -> out_data=0x36, out_valid exactly 1 edge after accept, blk_count=1 after the out_ready handshake.
2. ROUNDS=2, ROT=1: encrypt 0x41/0x5A -> 0x06. Then decrypt 0x06/0x5A -> 0x41.
3. Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_data stable, in_ready=0, and in_valid pulses are ignored. Releasing out_ready -> IDLE next edge.
4. abort in RUN at round 1 (ROUNDS=4) -> IDLE next edge, out_valid never rises, blk_count unchanged. A new request is accepted normally afterwards.
5. reset_n low mid-RUN -> all outputs at reset values immediately (asynchronous). After release, encrypt 0x41/0x5A with defaults; a reference model must match.
6. CNT_W=4: complete 17 blocks -> blk_count=1 (wrap). Random data/key sweep -> decrypt(encrypt(x))==x for 256 vectors.
